retire_unit: RTL
================

// Module: retire_unit
// PURPOSE
//  In-order retirement stage at the drain end of the reservation buffer (BUF_SIZE entries) that dispatch fills.
//  Each cycle it selects the up-to-two oldest live entries (largest tag first) and retires them in order.
//  A retired entry writes its result to the register file and frees its buffer slot.
//  Stores drain to data memory through a req/ack handshake.
//  Retires only non-speculative entries (speculative_tag == 0).
// PARAMETERS
//  BUF_SIZE      16  reservation buffer entries
//  BUF_SIZE_LOG  4   log2(BUF_SIZE); tag width is BUF_SIZE_LOG+1
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          asynchronous active-low reset
//  entries_all    in   entry[BUF_SIZE]  live buffer contents
//  reg_we         out  1[2]       register write enable, slot 0 = older
//  reg_waddr      out  5[2]       register write address (entry Dest)
//  reg_wdata      out  32[2]      register write data (entry result)
//  free_valid     out  1[2]       buffer must set entry free_index[k] to S_NOT_USED this edge
//  free_index     out  BUF_SIZE_LOG[2]  index of entry to free
//  store_retired  out  1          pulse; buffer decrements number_of_early_store_ops of every live entry
//  mem_req        out  1          store write request
//  mem_addr       out  32         store address (entry result)
//  mem_wdata      out  32         store data (entry Vk)
//  mem_ack        in   1          memory accepted write
// BEHAVIOUR
//  Interface
//   - Single clock clk; reset rst_n is asynchronous and active-low.
//   - Reset value of all outputs is 0. FSM resets to R_IDLE; inflight[BUF_SIZE] resets to 0.
//   - Reset mid-store drops mem_req immediately; the store is not retired.
//  Head selection (combinational)
//   - Candidates: e_state != S_NOT_USED and inflight[i] == 0.
//   - H0 = candidate with the largest tag; H1 = candidate with the second-largest tag.
//   - Tag compares are unsigned. Live tags never wrap, because dispatch stalls on is_tag_flooded.
//   - Hk is ready when e_state == S_EXECUTED and speculative_tag == 0.
//  Retirement
//   - Slot 1 retires only if slot 0 retires in the same cycle, H1 is ready, and neither H0 nor H1 is STORE.
//  FSM
//   - R_IDLE:
//     - H0 ready and non-STORE: register the retirement for slot 0 (and slot 1 if allowed); set inflight.
//     - H0 ready and STORE: latch mem_addr and mem_wdata, set inflight[H0], go to R_STORE.
//   - R_STORE:
//     - mem_req = 1; mem_addr and mem_wdata stay stable until mem_ack.
//     - No other retirement occurs in this state.
//     - On mem_ack: mem_req drops next cycle, store_retired pulses 1 cycle, free_valid[0] is set for the store, back to R_IDLE.
//  Output latency and pulses
//   - Latency is 1 cycle: an entry ready at cycle N gives reg_we, free_valid and free_index asserted during N+1.
//   - Outputs are single-cycle pulses.
//  Register writes and special cases
//   - reg_we[k] is suppressed when Dest == 0; the entry is still freed.
//   - BRANCH entries write only when Dest != 0.
//   - Both slots writing the same Dest: both asserted; the register file gives slot 1 priority (younger wins).
//  Inflight tracking
//   - inflight[i] is set at retirement.
//   - It clears the first cycle entries_all[i].e_state == S_NOT_USED.
//   - This prevents double retirement before the buffer update is visible.
//  Boundary cases
//   - Empty buffer, or H0 not ready: no outputs; FSM stays idle.
//   - Full buffer: no special case.
// TESTING
//  - Reset: rst_n=0 mid-R_STORE -> mem_req=0 immediately; after release, the store retires again from scratch.
//  - Dual retire: tags 15 and 14 both S_EXECUTED, Dest 3/4, results 0xA/0xB
//    -> next cycle reg_we={1,1}, waddr={3,4}, wdata={A,B}, free both indexes.
//  - Order block: tag 15 S_NOT_EXECUTED, tag 14 S_EXECUTED -> nothing retires until tag 15 executes.
//  - Speculative: head speculative_tag=6'b000100 -> held; cleared to 0 -> retires 1 cycle later.
//  - Store: head STORE result=0x100, Vk=0x55, mem_ack after 3 cycles
//    -> mem_req held 3 cycles with stable addr/data, then one store_retired pulse plus free; the younger ALU op retires the following cycle.
//  - Dest 0 and same Dest: Dest=0 head -> freed, reg_we=0.
//    Both slots Dest=5 -> both reg_we=1.
//    inflight entry still S_EXECUTED next cycle -> not retired twice.

Source files
------------

// File: rtl/retire_unit.sv
// In-order retirement stage: picks the two oldest live buffer entries,
// retires up to two ALU/BRANCH/LOAD entries per cycle and drains stores
// to data memory one at a time through a req/ack handshake.

package retire_pkg;
  localparam logic [1:0] S_NOT_USED     = 2'd0;
  localparam logic [1:0] S_NOT_EXECUTED = 2'd1;
  localparam logic [1:0] S_EXECUTED     = 2'd2;

  localparam logic [1:0] OP_ALU    = 2'd0;
  localparam logic [1:0] OP_BRANCH = 2'd1;
  localparam logic [1:0] OP_STORE  = 2'd2;
  localparam logic [1:0] OP_LOAD   = 2'd3;

  // Tag is BUF_SIZE_LOG+1 bits for the default 16-entry buffer.
  typedef struct packed {
    logic [1:0]  e_state;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic [5:0]  speculative_tag;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] vk;
  } entry_t;

  localparam int unsigned ENTRY_W = 84;
endpackage

module retire_unit
  import retire_pkg::*;
#(
  parameter int unsigned BUF_SIZE     = 16,
  parameter int unsigned BUF_SIZE_LOG = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [BUF_SIZE*ENTRY_W-1:0]     entries_all,
  output logic [1:0]                      reg_we,
  output logic [1:0][4:0]                 reg_waddr,
  output logic [1:0][31:0]                reg_wdata,
  output logic [1:0]                      free_valid,
  output logic [1:0][BUF_SIZE_LOG-1:0]    free_index,
  output logic                            store_retired,
  output logic                            mem_req,
  output logic [31:0]                     mem_addr,
  output logic [31:0]                     mem_wdata,
  input  logic                            mem_ack
);

  typedef enum logic {R_IDLE = 1'b0, R_STORE = 1'b1} rstate_t;

  entry_t                         ent_s [BUF_SIZE];
  logic                           h0_vld_s, h1_vld_s;
  logic [BUF_SIZE_LOG-1:0]        h0_idx_s, h1_idx_s;
  logic [4:0]                     h0_tag_s, h1_tag_s;
  entry_t                         h0_s, h1_s;
  logic                           h0_rdy_s, h1_rdy_s, slot1_ok_s;
  logic [BUF_SIZE-1:0]            inflight_q, inflight_d;

  rstate_t                        state_q;
  logic [1:0]                     reg_we_q, free_valid_q;
  logic [1:0][4:0]                reg_waddr_q;
  logic [1:0][31:0]               reg_wdata_q;
  logic [1:0][BUF_SIZE_LOG-1:0]   free_index_q;
  logic                           store_retired_q, mem_req_q;
  logic [31:0]                    mem_addr_q, mem_wdata_q;
  logic [BUF_SIZE_LOG-1:0]        store_idx_q;

  // Unpack the flat buffer view into entry records.
  always_comb begin
    for (int i = 0; i < BUF_SIZE; i++) begin
      ent_s[i] = entries_all[i*ENTRY_W +: ENTRY_W];
    end
  end

  // Find the two oldest (largest-tag) live entries not already retiring.
  always_comb begin
    h0_vld_s = 1'b0;
    h1_vld_s = 1'b0;
    h0_idx_s = '0;
    h1_idx_s = '0;
    h0_tag_s = 5'd0;
    h1_tag_s = 5'd0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (ent_s[i].e_state != S_NOT_USED && !inflight_q[i]) begin
        if (!h0_vld_s || ent_s[i].tag > h0_tag_s) begin
          h1_vld_s = h0_vld_s;
          h1_idx_s = h0_idx_s;
          h1_tag_s = h0_tag_s;
          h0_vld_s = 1'b1;
          h0_idx_s = BUF_SIZE_LOG'(i);
          h0_tag_s = ent_s[i].tag;
        end else if (!h1_vld_s || ent_s[i].tag > h1_tag_s) begin
          h1_vld_s = 1'b1;
          h1_idx_s = BUF_SIZE_LOG'(i);
          h1_tag_s = ent_s[i].tag;
        end else begin
          h1_vld_s = h1_vld_s;
        end
      end else begin
        h0_vld_s = h0_vld_s;
      end
    end
  end

  // Readiness of the two heads and whether slot 1 may retire alongside slot 0.
  always_comb begin
    h0_s       = ent_s[h0_idx_s];
    h1_s       = ent_s[h1_idx_s];
    h0_rdy_s   = h0_vld_s && h0_s.e_state == S_EXECUTED && h0_s.speculative_tag == 6'd0;
    h1_rdy_s   = h1_vld_s && h1_s.e_state == S_EXECUTED && h1_s.speculative_tag == 6'd0;
    slot1_ok_s = h0_rdy_s && h0_s.op != OP_STORE && h1_rdy_s && h1_s.op != OP_STORE;
  end

  // Inflight next state: clear once the buffer shows the slot free, set on retirement.
  always_comb begin
    inflight_d = inflight_q;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (ent_s[i].e_state == S_NOT_USED) begin
        inflight_d[i] = 1'b0;
      end else begin
        inflight_d[i] = inflight_q[i];
      end
    end
    if (state_q == R_IDLE && h0_rdy_s) begin
      inflight_d[h0_idx_s] = 1'b1;
    end else begin
      inflight_d = inflight_d;
    end
    if (state_q == R_IDLE && slot1_ok_s) begin
      inflight_d[h1_idx_s] = 1'b1;
    end else begin
      inflight_d = inflight_d;
    end
  end

  // Inflight register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // Retirement FSM with registered single-cycle output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= R_IDLE;
      reg_we_q        <= 2'b00;
      reg_waddr_q     <= '0;
      reg_wdata_q     <= '0;
      free_valid_q    <= 2'b00;
      free_index_q    <= '0;
      store_retired_q <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      store_idx_q     <= '0;
    end else begin
      reg_we_q        <= 2'b00;
      reg_waddr_q     <= '0;
      reg_wdata_q     <= '0;
      free_valid_q    <= 2'b00;
      free_index_q    <= '0;
      store_retired_q <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (h0_rdy_s && h0_s.op != OP_STORE) begin
            reg_we_q[0]     <= (h0_s.dest != 5'd0);
            reg_waddr_q[0]  <= h0_s.dest;
            reg_wdata_q[0]  <= h0_s.result;
            free_valid_q[0] <= 1'b1;
            free_index_q[0] <= h0_idx_s;
            if (slot1_ok_s) begin
              reg_we_q[1]     <= (h1_s.dest != 5'd0);
              reg_waddr_q[1]  <= h1_s.dest;
              reg_wdata_q[1]  <= h1_s.result;
              free_valid_q[1] <= 1'b1;
              free_index_q[1] <= h1_idx_s;
            end else begin
              free_valid_q[1] <= 1'b0;
            end
          end else if (h0_rdy_s) begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= h0_s.result;
            mem_wdata_q <= h0_s.vk;
            store_idx_q <= h0_idx_s;
            state_q     <= R_STORE;
          end else begin
            state_q <= R_IDLE;
          end
        end
        R_STORE: begin
          if (mem_ack) begin
            mem_req_q       <= 1'b0;
            store_retired_q <= 1'b1;
            free_valid_q[0] <= 1'b1;
            free_index_q[0] <= store_idx_q;
            state_q         <= R_IDLE;
          end else begin
            state_q <= R_STORE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= R_IDLE;
        end
      endcase
    end
  end

  assign reg_we        = reg_we_q;
  assign reg_waddr     = reg_waddr_q;
  assign reg_wdata     = reg_wdata_q;
  assign free_valid    = free_valid_q;
  assign free_index    = free_index_q;
  assign store_retired = store_retired_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
